// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encodings, segment bases
// and segment size, plus the segment address helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
  localparam logic [31:0] DATA_BASE = 32'h0000_2000;

  // One bit wider than the 11-bit word index so that "full" (2048) is representable.
  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] SEG_WORDS = 12'd2048;

  function automatic logic [31:0] seg_addr(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
    return base + {18'd0, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/boot_loader_seg_addr_counter.sv
// Word counter for one memory segment: clear, increment and full flag.
module seg_addr_counter
  import boot_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [CNT_W-1:0] count_r;

  // Clear wins over increment so a final word rewinds the segment to its base.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + 12'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign full  = (count_r == SEG_WORDS);

endmodule

// File: rtl/boot_loader.sv
// Streams a memory image into CPU memory (.text / .data segments), then
// releases the CPU from reset once go is seen.
module boot_loader
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_seg,
  input  logic        in_last,
  input  logic        go,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  state_t           state_r;
  state_t           state_s;
  logic             rel_cnt_r;
  logic             transfer_s;
  logic             sel_full_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic             wr_s;
  logic             ovf_s;
  logic             session_clr_s;
  logic [CNT_W-1:0] text_cnt_s;
  logic [CNT_W-1:0] data_cnt_s;
  logic             text_full_s;
  logic             data_full_s;

  assign in_ready      = (state_r == ST_LOAD) & ~go;
  assign transfer_s    = in_valid & in_ready;
  assign sel_full_s    = in_seg ? data_full_s : text_full_s;
  assign sel_cnt_s     = in_seg ? data_cnt_s : text_cnt_s;
  assign wr_s          = transfer_s & ~sel_full_s;
  assign ovf_s         = transfer_s & sel_full_s;
  assign session_clr_s = (state_r == ST_IDLE) & start;

  seg_addr_counter u_text_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (session_clr_s | (wr_s & ~in_seg & in_last)),
    .inc   (wr_s & ~in_seg & ~in_last),
    .count (text_cnt_s),
    .full  (text_full_s)
  );

  seg_addr_counter u_data_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (session_clr_s | (wr_s & in_seg & in_last)),
    .inc   (wr_s & in_seg & ~in_last),
    .count (data_cnt_s),
    .full  (data_full_s)
  );

  // State register and the two-cycle release timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rel_cnt_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      rel_cnt_r <= (state_r == ST_RELEASE) ? (rel_cnt_r + 1'b1) : 1'b0;
    end
  end

  // Next-state logic; go takes priority over any word offered the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (go)         state_s = ST_RELEASE;
        else if (ovf_s) state_s = ST_ERROR;
        else            state_s = ST_LOAD;
      end
      ST_RELEASE: begin
        if (rel_cnt_r) state_s = ST_RUN;
        else           state_s = ST_RELEASE;
      end
      ST_RUN:   state_s = ST_RUN;
      ST_ERROR: state_s = ST_ERROR;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Registered memory port and status; status follows the next state so it
  // changes on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= wr_s;
      if (wr_s) begin
        mem_addr  <= seg_addr(in_seg ? DATA_BASE : TEXT_BASE, sel_cnt_s);
        mem_wdata <= in_data;
      end else begin
        mem_addr  <= mem_addr;
        mem_wdata <= mem_wdata;
      end
      cpu_reset <= (state_s != ST_RUN);
      done      <= (state_s == ST_RUN);
      err       <= (state_s == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_seg, in_last, go;
  logic [31:0] in_data;
  logic        in_ready, mem_we, cpu_reset, done, err;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_seg(in_seg), .in_last(in_last), .go(go),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  typedef struct {
    logic rst, st, v, s, l, g;
    logic [31:0] d;
    logic e_ready, e_we;
    logic [31:0] e_addr, e_wdata;
    logic e_cpu, e_done, e_err;
  } vec_t;

  vec_t tbl[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model: mode 0 idle, 1 load, 2 release, 3 run, 4 error
  int mode = 0;
  int rel_left = 0;
  int cnt[2] = '{0, 0};
  logic x_we = 1'b0, x_cpu = 1'b1, x_done = 1'b0, x_err = 1'b0;
  logic [31:0] x_addr = 32'd0, x_wdata = 32'd0;

  int wr_seen = 0;
  logic [31:0] last_wr = 32'd0;

  function automatic vec_t mk(input logic rst, st, v, s, l, g, input logic [31:0] d,
                              input logic e_ready, e_we, input logic [31:0] e_addr, e_wdata,
                              input logic e_cpu, e_done, e_err);
    vec_t r;
    r.rst = rst; r.st = st; r.v = v; r.s = s; r.l = l; r.g = g; r.d = d;
    r.e_ready = e_ready; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata;
    r.e_cpu = e_cpu; r.e_done = e_done; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic apply(input logic rst, st, v, input logic [31:0] d, input logic s, l, g);
    reset = rst; start = st; in_valid = v; in_data = d; in_seg = s; in_last = l; go = g;
  endtask

  // Advances the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    int sg;
    if (reset) begin
      mode = 0; cnt[0] = 0; cnt[1] = 0;
      x_we = 1'b0; x_addr = 32'd0; x_wdata = 32'd0;
    end else begin
      x_we = 1'b0;
      case (mode)
        0: if (start) begin mode = 1; cnt[0] = 0; cnt[1] = 0; end
        1: begin
          if (go) begin
            mode = 2; rel_left = 2;
          end else if (in_valid) begin
            sg = in_seg ? 1 : 0;
            if (cnt[sg] == 2048) begin
              mode = 4;
            end else begin
              x_we = 1'b1;
              x_addr = (sg == 1 ? 32'h2000 : 32'h0) + 32'(4 * cnt[sg]);
              x_wdata = in_data;
              cnt[sg] = in_last ? 0 : cnt[sg] + 1;
            end
          end
        end
        2: begin rel_left--; if (rel_left == 0) mode = 3; end
        default: ;
      endcase
    end
    x_cpu = (mode != 3); x_done = (mode == 3); x_err = (mode == 4);
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [31:0] addr, wdata,
                            input logic cpu, dn, er);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cpu));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".err"}, 32'(err), 32'(er));
  endtask

  // One clock cycle checked against the model: in_ready mid-cycle, outputs after the edge.
  task automatic step(input logic rst, st, v, input logic [31:0] d, input logic s, l, g);
    apply(rst, st, v, d, s, l, g);
    #4;
    chk("model.in_ready", 32'(in_ready), 32'(mode == 1 && !g));
    model_edge();
    @(posedge clk); #1;
    check_outs("model", x_we, x_addr, x_wdata, x_cpu, x_done, x_err);
    if (mem_we === 1'b1) begin wr_seen++; last_wr = mem_addr; end
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    model_edge();
    @(posedge clk); #1;
    check_outs("reset", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);

    // Text load, release timing, RUN ignoring inputs, data load, same-cycle go
    tbl.push_back(mk(0,1,0,0,0,0,32'h0,        0,0,32'h0,   32'h0,        1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,32'h20080005, 1,1,32'h0,   32'h20080005, 1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,32'h20090007, 1,1,32'h4,   32'h20090007, 1,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,32'h01095020, 1,1,32'h8,   32'h01095020, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        1,0,32'h8,   32'h01095020, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h0,        0,0,32'h8,   32'h01095020, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,32'h8,   32'h01095020, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,32'h8,   32'h01095020, 0,1,0));
    tbl.push_back(mk(0,1,1,0,0,1,32'hDEADBEEF, 0,0,32'h8,   32'h01095020, 0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,32'h0,   32'h0,        1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,32'h0,        0,0,32'h0,   32'h0,        1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,32'hAAAA0000, 1,1,32'h0,   32'hAAAA0000, 1,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,32'h11111111, 1,1,32'h2000,32'h11111111, 1,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,32'h22222222, 1,1,32'h2004,32'h22222222, 1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,32'h33333333, 0,0,32'h2004,32'h22222222, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,32'h2004,32'h22222222, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,32'h2004,32'h22222222, 0,1,0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].l, tbl[i].g);
      #4;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
      model_edge();
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata,
                 tbl[i].e_cpu, tbl[i].e_done, tbl[i].e_err);
    end

    // Reset the cycle after a transfer drops the write strobe and restarts cleanly
    step(1, 0, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0, 0);
    step(0, 0, 1, 32'hCAFE0001, 0, 0, 0);
    chk("rst_mid.write_seen", 32'(mem_we), 32'd1);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    chk("rst_mid.we_after", 32'(mem_we), 32'd0);
    step(0, 1, 0, 32'h0, 0, 0, 0);
    step(0, 0, 1, 32'hCAFE0002, 0, 0, 0);
    chk("rst_mid.restart_addr", mem_addr, 32'h0);

    // Stall: valid 1,0,1 gives two writes at consecutive addresses with a gap
    step(0, 0, 1, 32'h5A5A0001, 0, 0, 0);
    chk("stall.addr1", mem_addr, 32'h4);
    step(0, 0, 0, 32'h0, 0, 0, 0);
    chk("stall.gap_we", 32'(mem_we), 32'd0);
    step(0, 0, 1, 32'h5A5A0002, 0, 0, 0);
    chk("stall.addr2", mem_addr, 32'h8);
    chk("stall.data2", mem_wdata, 32'h5A5A0002);

    // Overflow of the data segment
    step(1, 0, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0, 0);
    wr_seen = 0;
    for (int i = 0; i < 2049; i++) step(0, 0, 1, 32'(i), 1, 0, 0);
    chk("ovf.writes", 32'(wr_seen), 32'd2048);
    chk("ovf.last_addr", last_wr, 32'h3FFC);
    chk("ovf.err", 32'(err), 32'd1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    step(0, 1, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0, 0, 0);
    chk("ovf.cpu_reset_held", 32'(cpu_reset), 32'd1);
    chk("ovf.done_low", 32'(done), 32'd0);

    // Randomized traffic against the model
    step(1, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_st, r_v, r_s, r_l, r_g;
      r_rst = ($urandom_range(0, 59) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_v   = ($urandom_range(0, 2) != 0);
      r_s   = $urandom_range(0, 1) == 1;
      r_l   = ($urandom_range(0, 7) == 0);
      r_g   = ($urandom_range(0, 39) == 0);
      step(r_rst, r_st, r_v, $urandom, r_s, r_l, r_g);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
